// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie, the port not granted last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_idx,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = PORT_FETCH;
        if (req0 && req1)
            gnt_idx = ~last;
        else if (req1)
            gnt_idx = PORT_DATA;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one synchronous
// memory: IDLE arbitrates, ISSUE drives the strobe, WAIT captures read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    state_t        state_q, state_d;
    logic          last_q;
    logic          port_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          pick;
    logic          pick_vld;

    rr_arbiter2 u_rr (
        .req0    (req0),
        .req1    (req1),
        .last    (last_q),
        .gnt_idx (pick),
        .gnt_vld (pick_vld)
    );

    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

    always_comb begin
        state_d   = state_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_vld)
                    state_d = ISSUE;
            end
            ISSUE: begin
                gnt0      = (port_q == PORT_FETCH);
                gnt1      = (port_q == PORT_DATA);
                mem_write = we_q;
                mem_read  = ~we_q;
                state_d   = we_q ? IDLE : WAIT;
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= PORT_DATA;
            port_q  <= PORT_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state_q <= state_d;
            // rvalid marks the IDLE cycle right after WAIT, when rdata is fresh
            rvalid0 <= (state_q == WAIT) && (port_q == PORT_FETCH);
            rvalid1 <= (state_q == WAIT) && (port_q == PORT_DATA);
            if (state_q == IDLE && pick_vld) begin
                last_q  <= pick;
                port_q  <= pick;
                we_q    <= pick ? we1 : we0;
                addr_q  <= pick ? addr1 : addr0;
                wdata_q <= pick ? wdata1 : wdata0;
            end
            if (state_q == WAIT)
                rdata <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level model of grants and reads.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_read, mem_write;
    logic [7:0] rdata, mem_data_in;
    logic [7:0] mem_data_out = '0;
    logic [3:0] mem_address;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_mem [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16];

    mem_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous memory: strobes sampled on the edge, read data valid next cycle.
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_address] <= mem_data_in;
        if (mem_read)  mem_data_out <= tb_mem[mem_address];
    end

    always @(negedge clk) begin
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL strobe_mutex: mem_read=%0b mem_write=%0b, must not both be 1", mem_read, mem_write);
        end
        checks++;
        if (gnt0 && gnt1) begin
            errors++;
            $display("FAIL gnt_mutex: gnt0=%0b gnt1=%0b, must not both be 1", gnt0, gnt1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_reqs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       r0, w0; logic [3:0] a0; logic [7:0] d0;
        logic       r1, w1; logic [3:0] a1; logic [7:0] d1;
        logic       eg1;   // expected winner is port 1
        logic       erd;   // expected access is a read
        logic [3:0] ea;
        logic [7:0] ed;    // write data, or read data for reads
    } vec_t;

    vec_t tbl [6];

    // random-phase model state
    logic       pend [2];
    logic       pwe [2];
    logic [3:0] pa [2];
    logic [7:0] pd [2];
    int         free_at, gcyc, rvc, gw, rvp, lastp, jg;
    logic [7:0] rvd, last_rd;
    int         n, first_c, last_c;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'h2, 8'hAA, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h2, 8'hAA};
        tbl[1] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h3, 8'hBB, 1'b1, 1'b0, 4'h3, 8'hBB};
        tbl[2] = '{1'b1, 1'b1, 4'h5, 8'h11, 1'b1, 1'b1, 4'h6, 8'h22, 1'b0, 1'b0, 4'h5, 8'h11};
        tbl[3] = '{1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b1, 4'h3, 8'hBB};
        tbl[4] = '{1'b1, 1'b0, 4'h6, 8'h00, 1'b1, 1'b1, 4'h7, 8'h33, 1'b0, 1'b1, 4'h6, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b1, 4'h5, 8'h11};

        // Reset state
        step();
        chk("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy}, 0);
        chk("reset_addr", mem_address, 0);
        chk("reset_wdata", mem_data_in, 0);
        chk("reset_rdata", rdata, 0);
        step();
        rst_n = 1'b1;

        // Vector table, starting from reset (port 0 wins the first tie)
        for (int i = 0; i < 6; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            step();
            chk($sformatf("tbl%0d_gnt", i), {gnt1, gnt0}, tbl[i].eg1 ? 2'b10 : 2'b01);
            chk($sformatf("tbl%0d_strobe", i), {mem_read, mem_write}, tbl[i].erd ? 2'b10 : 2'b01);
            chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].ea);
            if (!tbl[i].erd) chk($sformatf("tbl%0d_wdata", i), mem_data_in, tbl[i].ed);
            drop_reqs();
            step();
            if (tbl[i].erd) begin
                step();
                chk($sformatf("tbl%0d_rvalid", i), {rvalid1, rvalid0}, tbl[i].eg1 ? 2'b10 : 2'b01);
                chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].ed);
            end
            chk($sformatf("tbl%0d_busy", i), busy, 0);
        end

        // Port 1 write then read of address 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h1; wdata1 = 8'hF0;
        step();
        chk("wr_gnt1", {gnt1, gnt0, mem_write, mem_read}, 4'b1010);
        chk("wr_addr", mem_address, 4'h1);
        chk("wr_data", mem_data_in, 8'hF0);
        drop_reqs();
        step();
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h1;
        step();
        drop_reqs();
        step();
        chk("rd_early", {rvalid1, rvalid0}, 0);
        step();
        chk("rd_rvalid1", {rvalid1, rvalid0}, 2'b10);
        chk("rd_rdata", rdata, 8'hF0);

        // Simultaneous reads after reset, both held until granted
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        step();
        chk("sim_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        step();
        chk("sim_wait_nognt", {gnt1, gnt0}, 0);
        step();
        chk("sim_rvalid0", {rvalid1, rvalid0, gnt1}, 3'b010);
        chk("sim_rdata0", rdata, 8'hAA);
        step();
        chk("sim_gnt1", {gnt1, gnt0, mem_read}, 3'b101);
        chk("sim_addr1", mem_address, 4'h3);
        req1 = 1'b0;
        step();
        step();
        chk("sim_rvalid1", {rvalid1, rvalid0}, 2'b10);
        chk("sim_rdata1", rdata, 8'hBB);

        // Fairness: continuous writes from both ports alternate
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h8; wdata0 = 8'h80;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h9; wdata1 = 8'h90;
        n = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            step();
            if (gnt0 || gnt1) begin
                chk($sformatf("fair%0d", n), {gnt1, gnt0}, (n % 2) ? 2'b10 : 2'b01);
                if (n == 0) first_c = c;
                last_c = c;
                n++;
            end
        end
        drop_reqs();
        chk("fair_count", n, 8);
        chk("fair_span", last_c - first_c, 14);
        step();

        // Hold-off: req0 raised during port 1's WAIT
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        step();
        chk("hold_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h2;
        chk("hold_wait_busy", busy, 1);
        step();
        chk("hold_idle_nognt", {gnt1, gnt0, rvalid1}, 3'b001);
        chk("hold_rdata1", rdata, 8'hBB);
        step();
        chk("hold_gnt0", {gnt1, gnt0}, 2'b01);
        chk("hold_addr0", mem_address, 4'h2);
        req0 = 1'b0;
        step();
        step();
        chk("hold_rvalid0", {rvalid1, rvalid0}, 2'b01);
        chk("hold_rdata0", rdata, 8'hAA);

        // Reset during a write ISSUE kills the strobe; the write never lands
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h4; wdata0 = 8'h55;
        step();
        chk("rstw_issue", mem_write, 1);
        rst_n = 1'b0;
        drop_reqs();
        #1;
        chk("rstw_strobe", {mem_write, gnt0, busy}, 0);
        step();
        step();
        rst_n = 1'b1;
        chk("rstw_nowrite", tb_mem[4], 8'h00);

        // Reset during WAIT aborts the read
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        step();
        chk("rstr_gnt0", gnt0, 1);
        req0 = 1'b0;
        step();
        chk("rstr_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstr_abort", {busy, mem_read, rvalid0, rvalid1}, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rstr_norvalid%0d", c), {rvalid1, rvalid0}, 0);
            step();
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        step();
        req1 = 1'b0;
        step();
        step();
        chk("rstr_next_rvalid", {rvalid1, rvalid0}, 2'b10);
        chk("rstr_next_rdata", rdata, 8'hAA);

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = tb_mem[i];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0;
        end
        free_at = 0; gcyc = -1; rvc = -1; gw = 0; rvp = 0; lastp = 1;
        rvd = '0; last_rd = '0;
        for (int t = 0; t < 400; t++) begin
            jg = -1;
            if (t == gcyc) begin
                chk("rnd_gnt", {gnt1, gnt0}, gw ? 2'b10 : 2'b01);
                chk("rnd_strobe", {mem_read, mem_write}, pwe[gw] ? 2'b01 : 2'b10);
                chk("rnd_addr", mem_address, pa[gw]);
                if (pwe[gw]) begin
                    chk("rnd_wdata", mem_data_in, pd[gw]);
                    ref_mem[pa[gw]] = pd[gw];
                    free_at = t + 1;
                end else begin
                    rvc = t + 2; rvp = gw; rvd = ref_mem[pa[gw]];
                    free_at = t + 2;
                end
                lastp = gw; pend[gw] = 1'b0; jg = gw;
            end else begin
                chk("rnd_idle", {gnt1, gnt0, mem_read, mem_write}, 0);
            end
            if (t == rvc) begin
                chk("rnd_rvalid", {rvalid1, rvalid0}, rvp ? 2'b10 : 2'b01);
                last_rd = rvd;
            end else begin
                chk("rnd_norvalid", {rvalid1, rvalid0}, 0);
            end
            chk("rnd_rdata", rdata, last_rd);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && p != jg && $urandom_range(2) == 0) begin
                    pend[p] = 1'b1;
                    pwe[p]  = 1'($urandom_range(1));
                    pa[p]   = 4'($urandom_range(15));
                    pd[p]   = 8'($urandom_range(255));
                end
            end
            req0 = pend[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
            req1 = pend[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
            if (t == free_at) begin
                if (pend[0] || pend[1]) begin
                    gw = (pend[0] && pend[1]) ? 1 - lastp : (pend[0] ? 0 : 1);
                    gcyc = t + 1;
                end else begin
                    free_at = t + 1;
                end
            end
            step();
        end
        drop_reqs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
